// File: rtl/spi_dac_pkg.sv
// ============================================================================
// Module   : spi_dac_pkg
// Purpose  : Shared types and constants for the spi_dac_slave SPI DAC
//            responder: FSM states, command codes and frame field positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_dac_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Command codes carried in frame bits [27:24]
  localparam logic [3:0] CMD_WR_IN      = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;
  localparam logic [3:0] CMD_RESET      = 4'h7;
  localparam logic [3:0] CMD_SETUP_REF  = 4'h8;

  // Broadcast address
  localparam logic [3:0] ADDR_ALL = 4'hF;

  // Field bit positions inside a 32-bit frame
  localparam int CMD_LSB  = 24;
  localparam int ADDR_LSB = 20;
  localparam int DATA_LSB = 8;
  localparam int REF_BIT  = 0;

  // True for every command code the responder acts on
  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_WR_IN) || (cmd == CMD_UPD) || (cmd == CMD_WR_UPD_ALL) ||
           (cmd == CMD_WR_UPD) || (cmd == CMD_RESET) || (cmd == CMD_SETUP_REF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_dac_slave_sync.sv
// ============================================================================
// Module   : spi_in_sync
// Purpose  : STAGES-deep synchronizer for one asynchronous SPI pin, plus a
//            history flop giving single-cycle rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Shift the pin through the synchronizer chain and remember the last level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~hist;
  assign fall = ~chain[STAGES-1] & hist;

endmodule

`default_nettype wire

// File: rtl/spi_dac_slave.sv
// ============================================================================
// Module   : spi_dac_slave
// Purpose  : Oversampling SPI responder modelling an AD5628-style DAC.
//            Captures 32-bit frames, decodes cmd/addr/data and maintains
//            per-channel input and DAC registers plus the reference enable.
//            Optional macro SPI_DAC_MISO_EN: echo previous frame on miso.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_dac_slave
  import spi_dac_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int FRAME_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk100mhz,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  output logic [NUM_CH*DATA_W-1:0] dac_out,
  output logic                     ref_en,
  output logic                     frame_valid,
  output logic [FRAME_W-1:0]       frame_word,
  output logic                     frame_err,
  output logic                     cmd_err
);

  localparam int             CNT_W     = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  // cs idles high so its synchronizer resets high: no false edge after reset
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk100mhz), .rst_n(rst_n), .din(cs),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk100mhz), .rst_n(rst_n), .din(sclk),
    .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk100mhz), .rst_n(rst_n), .din(mosi),
    .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic                 cnt_clr, shift_en, decode_en, len_err;

  // FSM state register
  always_ff @(posedge clk100mhz) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a cs fall seen during DECODE starts the next frame directly
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = (bit_cnt == CNT_FRAME) ? DECODE : IDLE;
      DECODE:  state_nxt = cs_fall ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: counter clear, bit capture, decode strobe, length error
  always_comb begin
    cnt_clr   = (state == IDLE || state == DECODE) && cs_fall;
    shift_en  = (state == SHIFT) && sclk_fall && !cs_s;
    decode_en = (state == DECODE);
    len_err   = (state == SHIFT) && cs_rise &&
                (bit_cnt != CNT_FRAME) && (bit_cnt != '0);
  end

  // Capture mosi MSB first; the counter saturates one past a full frame
  always_ff @(posedge clk100mhz) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_W-2:0], mosi_s};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Frame field decode
  logic [3:0]        cmd, addr;
  logic [DATA_W-1:0] data;
  logic              addr_ok;
  logic [NUM_CH-1:0] sel;

  assign cmd  = shreg[CMD_LSB +: 4];
  assign addr = shreg[ADDR_LSB +: 4];
  assign data = shreg[DATA_LSB +: DATA_W];

  // Channel select; out-of-range addresses select nothing
  always_comb begin
    sel     = '0;
    addr_ok = (addr == ADDR_ALL) || (32'(addr) < NUM_CH);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sel[ch] = (addr == ADDR_ALL) || (32'(addr) == ch);
    end
  end

  logic [DATA_W-1:0] in_reg  [NUM_CH];
  logic [DATA_W-1:0] dac_reg [NUM_CH];

  // Apply the decoded command and latch the frame
  always_ff @(posedge clk100mhz) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        in_reg[ch]  <= '0;
        dac_reg[ch] <= '0;
      end
      ref_en     <= 1'b0;
      frame_word <= '0;
    end else if (decode_en) begin
      frame_word <= shreg;
      case (cmd)
        CMD_WR_IN: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (sel[ch]) in_reg[ch] <= data;
        end
        CMD_UPD: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (sel[ch]) dac_reg[ch] <= in_reg[ch];
        end
        CMD_WR_UPD_ALL: begin
          // Invalid address drops the whole command, including the update
          if (addr_ok) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
              if (sel[ch]) begin
                in_reg[ch]  <= data;
                dac_reg[ch] <= data;
              end else begin
                dac_reg[ch] <= in_reg[ch];
              end
            end
          end
        end
        CMD_WR_UPD: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel[ch]) begin
              in_reg[ch]  <= data;
              dac_reg[ch] <= data;
            end
          end
        end
        CMD_RESET: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            in_reg[ch]  <= '0;
            dac_reg[ch] <= '0;
          end
          ref_en <= 1'b0;
        end
        CMD_SETUP_REF: ref_en <= shreg[REF_BIT];
        default: ;
      endcase
    end
  end

  // One-cycle status pulses, aligned with the register update
  always_ff @(posedge clk100mhz) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      frame_valid <= decode_en;
      frame_err   <= len_err;
      cmd_err     <= decode_en && !cmd_supported(cmd);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_dac_out
    assign dac_out[ch*DATA_W +: DATA_W] = dac_reg[ch];
  end

`ifdef SPI_DAC_MISO_EN
  logic [FRAME_W-1:0] echo;

  // Echo the previous frame: MSB at cs fall, next bit on each sclk rise
  always_ff @(posedge clk100mhz) begin
    if (!rst_n) begin
      echo <= '0;
      miso <= 1'b0;
    end else if (cs_fall) begin
      miso <= frame_word[FRAME_W-1];
      echo <= {frame_word[FRAME_W-2:0], 1'b0};
    end else if (cs_s) begin
      miso <= 1'b0;
    end else if (sclk_rise) begin
      miso <= echo[FRAME_W-1];
      echo <= {echo[FRAME_W-2:0], 1'b0};
    end
  end
`else
  logic unused_sclk_rise;
  assign unused_sclk_rise = sclk_rise;
  assign miso = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_dac_slave.sv
// ============================================================================
// Module   : tb_spi_dac_slave
// Purpose  : Self-checking bench for spi_dac_slave: directed frames from the
//            test plan followed by random frames against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_dac_slave;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int SYNC   = 2;
  localparam int HALF   = 5;   // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst_n, cs, sclk, mosi;
  logic        miso, ref_en, frame_valid, frame_err, cmd_err;
  logic [95:0] dac_out;
  logic [31:0] frame_word;

  spi_dac_slave #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(32), .SYNC_STAGES(SYNC)) dut (
    .clk100mhz(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .dac_out(dac_out), .ref_en(ref_en), .frame_valid(frame_valid),
    .frame_word(frame_word), .frame_err(frame_err), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt = 0, fe_cnt = 0, ce_cnt = 0;

  // Pulse counters
  always @(posedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (cmd_err)     ce_cnt <= ce_cnt + 1;
  end

  // Behavioural model state
  logic [11:0] m_in  [NUM_CH];
  logic [11:0] m_dac [NUM_CH];
  logic        m_ref;
  logic [31:0] m_fw;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_in[c] = '0;
      m_dac[c] = '0;
    end
    m_ref = 1'b0;
    m_fw  = '0;
  endtask

  function automatic logic [95:0] model_dac();
    logic [95:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c*12 +: 12] = m_dac[c];
    return v;
  endfunction

  // Apply one full frame to the model; returns 1 if the command is supported
  function automatic logic model_apply(input logic [31:0] w);
    int  cmd  = int'(w[27:24]);
    int  addr = int'(w[23:20]);
    logic [11:0] d = w[19:8];
    logic known = 1'b1;
    m_fw = w;
    for (int c = 0; c < NUM_CH; c++) begin
      logic hit = (addr == 15) || (addr == c);
      case (cmd)
        0: if (hit) m_in[c] = d;
        1: if (hit) m_dac[c] = m_in[c];
        3: if (hit) begin m_in[c] = d; m_dac[c] = d; end
        default: ;
      endcase
    end
    if (cmd == 2 && (addr == 15 || addr < NUM_CH)) begin
      for (int c = 0; c < NUM_CH; c++) if (addr == 15 || addr == c) m_in[c] = d;
      for (int c = 0; c < NUM_CH; c++) m_dac[c] = m_in[c];
    end
    if (cmd == 7) begin
      for (int c = 0; c < NUM_CH; c++) begin m_in[c] = '0; m_dac[c] = '0; end
      m_ref = 1'b0;
    end
    if (cmd == 8) m_ref = w[0];
    if (!(cmd <= 3 || cmd == 7 || cmd == 8)) known = 1'b0;
    return known;
  endfunction

  // Send nbits of w MSB first; abort_at >= 0 pulses reset at that bit
  task automatic run_frame(input string tag, input logic [31:0] w, input int nbits, input int abort_at);
    int fv0 = fv_cnt, fe0 = fe_cnt, ce0 = ce_cnt;
    int lat = 0, exp_fv = 0, exp_fe = 0, exp_ce = 0;
    logic aborted = 1'b0;
    logic [31:0] cap = '0;
    logic [31:0] exp_echo;
`ifdef SPI_DAC_MISO_EN
    exp_echo = m_fw;
`else
    exp_echo = '0;
`endif
    @(negedge clk) cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        aborted = 1'b1;
        break;
      end
      if (i < 32) cap[31-i] = miso;
      sclk = 1'b1;
      mosi = (i < 32) ? w[31-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    cs = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (frame_valid && lat == 0) lat = k;
    end
    if (!aborted && nbits == 32) begin
      exp_fv = 1;
      exp_ce = model_apply(w) ? 0 : 1;
      chk({tag, "/latency"}, 128'(lat), 128'(SYNC + 2));
      chk({tag, "/miso_echo"}, 128'(cap), 128'(exp_echo));
    end else if (!aborted && nbits > 0) begin
      exp_fe = 1;
    end
    chk({tag, "/frame_valid"}, 128'(fv_cnt - fv0), 128'(exp_fv));
    chk({tag, "/frame_err"},   128'(fe_cnt - fe0), 128'(exp_fe));
    chk({tag, "/cmd_err"},     128'(ce_cnt - ce0), 128'(exp_ce));
    chk({tag, "/dac_out"},     128'(dac_out), 128'(model_dac()));
    chk({tag, "/ref_en"},      128'(ref_en), 128'(m_ref));
    chk({tag, "/frame_word"},  128'(frame_word), 128'(m_fw));
    chk({tag, "/miso_idle"},   128'(miso), 128'(0));
  endtask

  initial begin
    logic [31:0] w;
    int nb;
    logic [3:0] c, a;
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("reset/dac_out", 128'(dac_out), 128'(0));
    chk("reset/ref_en", 128'(ref_en), 128'(0));
    chk("reset/frame_word", 128'(frame_word), 128'(0));
    chk("reset/pulses", 128'({frame_valid, frame_err, cmd_err}), 128'(0));
    chk("reset/miso", 128'(miso), 128'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("ref_on",   32'h08000001, 32, -1);
    run_frame("wr_upd0",  32'h030ABC00, 32, -1);
    run_frame("wr_in3",   32'h00355500, 32, -1);
    run_frame("upd3",     32'h01300000, 32, -1);
    run_frame("bcast",    32'h03F12300, 32, -1);
    run_frame("swreset",  32'h07000000, 32, -1);
    run_frame("short20",  32'h03012300, 20, -1);
    run_frame("badcmd",   32'h05000000, 32, -1);
    run_frame("bad_addr", 32'h039AAA00, 32, -1);
    run_frame("empty",    32'h00000000, 0,  -1);
    run_frame("long33",   32'h030AAA00, 33, -1);
    run_frame("prep",     32'h03F55500, 32, -1);
    run_frame("abort",    32'h030FFF00, 32, 16);
    run_frame("post_rst", 32'h03012300, 32, -1);

    for (int n = 0; n < 60; n++) begin
      int r = int'($urandom_range(0, 9));
      int p = int'($urandom_range(0, 8));
      case (p)
        0, 6:    c = 4'h0;
        1:       c = 4'h1;
        2, 7:    c = 4'h2;
        3, 5:    c = 4'h3;
        4:       c = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'h8;
        default: c = 4'($urandom_range(4, 15));
      endcase
      if (p == 8 && (c == 4'h7 || c == 4'h8)) c = 4'h5;
      a = 4'($urandom_range(0, 15));
      if (c == 4'h2 && a >= 4'(NUM_CH) && a != 4'hF) a = 4'hF;
      w = {4'($urandom), c, a, 12'($urandom), 8'($urandom)};
      if (r == 0)      nb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 31)) : 33;
      else if (r == 1) nb = 0;
      else             nb = 32;
      run_frame($sformatf("rnd%0d", n), w, nb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
